// File: rtl/adc_bcd_format_if.sv
// Sample-in / BCD-display-out bundle for adc_bcd_format.
// master drives the sample strobe; slave is the converter.
interface adc_bcd_format_if #(
    parameter int IN_W = 14
);
    logic            i_valid;
    logic [IN_W-1:0] i_sample;
    logic            i_blank_en;
    logic [1:0]      i_dp_pos;
    logic            o_busy;
    logic            o_done;
    logic [15:0]     o_data;
    logic [3:0]      o_turn_off;
    logic [3:0]      o_dp;
    logic            o_ovf;

    modport master (
        output i_valid, i_sample, i_blank_en, i_dp_pos,
        input  o_busy, o_done, o_data, o_turn_off, o_dp, o_ovf
    );

    modport slave (
        input  i_valid, i_sample, i_blank_en, i_dp_pos,
        output o_busy, o_done, o_data, o_turn_off, o_dp, o_ovf
    );
endinterface

// File: rtl/adc_bcd_format.sv
// Binary ADC sample to 4-digit BCD (double dabble) with blanking and point.
// ADC_BCD_SAT_EN: clamp values above 9999 to 9999 and flag o_ovf.
module adc_bcd_format #(
    parameter int IN_W = 14
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    adc_bcd_format_if.slave    bus
);
    localparam int CW = $clog2(IN_W + 1);
    localparam int SW = 20 + IN_W;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        OUT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_sh;
    logic            r_blank;
    logic [1:0]      r_dp_pos;
    logic [15:0]     r_data;
    logic [3:0]      r_off;
    logic [3:0]      r_dp;
    logic            r_done;

    logic            w_accept;
    logic [IN_W-1:0] w_load;
    logic [SW-1:0]   w_adj;
    logic [15:0]     w_low;
    logic [3:0]      w_prot;
    logic [3:0]      w_off;
    logic [3:0]      w_dp;

    assign w_accept = (r_state == IDLE) && bus.i_valid;

`ifdef ADC_BCD_SAT_EN
    logic w_over;
    logic r_ovf_cap;
    logic r_ovf;

    assign w_over = 32'(bus.i_sample) > 32'd9999;
    assign w_load = w_over ? IN_W'(9999) : bus.i_sample;
    assign bus.o_ovf = r_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf_cap <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_accept)
                r_ovf_cap <= w_over;
            if (r_state == OUT)
                r_ovf <= r_ovf_cap;
        end
    end
`else
    assign w_load = bus.i_sample;
    assign bus.o_ovf = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.i_valid) w_next = SHIFT;
            SHIFT:   if (r_cnt == CW'(1)) w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Add-3 correction on all five BCD nibbles before each shift.
    always_comb begin
        w_adj = r_sh;
        for (int k = 0; k < 5; k++) begin
            if (r_sh[IN_W + 4*k +: 4] >= 4'd5)
                w_adj[IN_W + 4*k +: 4] = r_sh[IN_W + 4*k +: 4] + 4'd3;
        end
    end

    assign w_low = r_sh[IN_W +: 16];

    // A digit at or right of the point is never blanked.
    always_comb begin
        w_prot    = 4'b0001;
        w_prot[1] = (r_dp_pos >= 2'd1);
        w_prot[2] = (r_dp_pos >= 2'd2);
        w_prot[3] = (r_dp_pos == 2'd3);
        w_off     = 4'b0000;
        w_off[3]  = r_blank && (w_low[15:12] == 4'd0) && !w_prot[3];
        w_off[2]  = w_off[3] && (w_low[11:8] == 4'd0) && !w_prot[2];
        w_off[1]  = w_off[2] && (w_low[7:4] == 4'd0) && !w_prot[1];
        w_dp      = 4'b0000;
        if (r_dp_pos != 2'd0)
            w_dp = 4'b0001 << r_dp_pos;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_sh     <= '0;
            r_blank  <= 1'b0;
            r_dp_pos <= 2'd0;
            r_data   <= 16'h0000;
            r_off    <= 4'b1111;
            r_dp     <= 4'b0000;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt    <= CW'(IN_W);
                r_sh     <= {20'd0, w_load};
                r_blank  <= bus.i_blank_en;
                r_dp_pos <= bus.i_dp_pos;
            end
            if (r_state == SHIFT) begin
                r_cnt <= r_cnt - CW'(1);
                r_sh  <= {w_adj[SW-2:0], 1'b0};
            end
            if (r_state == OUT) begin
                r_data <= w_low;
                r_off  <= w_off;
                r_dp   <= w_dp;
                r_done <= 1'b1;
            end
        end
    end

    assign bus.o_busy     = (r_state != IDLE);
    assign bus.o_done     = r_done;
    assign bus.o_data     = r_data;
    assign bus.o_turn_off = r_off;
    assign bus.o_dp       = r_dp;
endmodule
